// File: rtl/cy_ctrl_pkg.sv
// Shared constants, types and parameter legality check for the
// extended control register family.
package cy_ctrl_pkg;

    localparam int CY_CTRL_MAX_WIDTH = 32;
    localparam int CY_CTRL_MAX_PULSE = 16;

    // Five bits hold PULSE_LEN up to CY_CTRL_MAX_PULSE.
    typedef logic [4:0] pulse_cnt_t;

    function automatic bit cy_ctrl_params_ok(input int width, input int pulse_len, input int staged);
        return (width >= 1) && (width <= CY_CTRL_MAX_WIDTH) &&
               (pulse_len >= 1) && (pulse_len <= CY_CTRL_MAX_PULSE) &&
               ((staged == 0) || (staged == 1));
    endfunction

endpackage

// File: rtl/cy_ctrl_pulse_gen.sv
// Shared pulse engine: one down-counter plus the set of bits currently
// being strobed. A launch ORs new bits in and restarts the count.
module cy_ctrl_pulse_gen
    import cy_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PULSE_LEN = 1
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_launch,
    input  logic [WIDTH-1:0] i_launch_mask,
    output logic [WIDTH-1:0] o_pulse,
    output logic             o_busy
);

    localparam pulse_cnt_t LEN = pulse_cnt_t'(PULSE_LEN);

    pulse_cnt_t       r_count;
    logic [WIDTH-1:0] r_active;

    // r_active is cleared on the same edge the count reaches zero, so it
    // can drive the fabric directly without gating against the counter.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count  <= '0;
            r_active <= '0;
        end else if (i_launch) begin
            r_count  <= LEN;
            r_active <= r_active | i_launch_mask;
        end else if (r_count != '0) begin
            r_count <= r_count - 5'd1;
            if (r_count == 5'd1) begin
                r_active <= '0;
            end
        end
    end

    assign o_pulse = r_active;
    assign o_busy  = (r_count != '0);

endmodule

// File: rtl/cy_control_reg_ext.sv
// CPU-writable control register with level/pulse bits, optional staged
// commit and a registered one-cycle ack with readback.
module cy_control_reg_ext
    import cy_ctrl_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] PULSE_MASK = '0,
    parameter int               PULSE_LEN  = 1,
    parameter int               STAGED     = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             bus_wr,
    input  logic [WIDTH-1:0] bus_wdata,
    input  logic             bus_rd,
    output logic [WIDTH-1:0] bus_rdata,
    output logic             bus_ack,
    input  logic             commit,
    output logic [WIDTH-1:0] control,
    output logic             pending,
    output logic             pulse_active
);

    localparam logic [WIDTH-1:0] LEVEL_MASK  = ~PULSE_MASK;
    localparam logic [WIDTH-1:0] LEVEL_RESET = RESET_VAL & LEVEL_MASK;

    if (!cy_ctrl_params_ok(WIDTH, PULSE_LEN, STAGED)) begin : g_bad_params
        $error("cy_control_reg_ext: illegal WIDTH/PULSE_LEN/STAGED");
    end

    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_stage;
    logic             r_pending;
    logic             r_ack;
    logic [WIDTH-1:0] r_rdata;

    logic             w_commit;
    logic             w_launch;
    logic [WIDTH-1:0] w_launch_mask;
    logic [WIDTH-1:0] w_readback;
    logic [WIDTH-1:0] w_pulse;
    logic             w_busy;

    always_comb begin
        w_commit      = (STAGED != 0) && commit;
        w_launch_mask = bus_wdata & PULSE_MASK;
        w_launch      = bus_wr && (|w_launch_mask);
        w_readback    = r_level;
        if (STAGED != 0) begin
            w_launch_mask = r_stage & PULSE_MASK;
            w_launch      = w_commit && (|w_launch_mask);
            w_readback    = r_stage;
        end
    end

    // On a write/commit collision the commit consumes the old staging
    // contents while the new write lands in staging and stays pending.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_level   <= LEVEL_RESET;
            r_stage   <= LEVEL_RESET;
            r_pending <= 1'b0;
            r_ack     <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_ack <= bus_wr | bus_rd;
            if (bus_wr | bus_rd) begin
                r_rdata <= w_readback;
            end
            if (STAGED != 0) begin
                if (w_commit) begin
                    r_level <= r_stage & LEVEL_MASK;
                end
                if (bus_wr) begin
                    r_stage   <= bus_wdata;
                    r_pending <= 1'b1;
                end else if (w_commit) begin
                    r_stage   <= r_stage & LEVEL_MASK;
                    r_pending <= 1'b0;
                end
            end else if (bus_wr) begin
                r_level <= bus_wdata & LEVEL_MASK;
            end
        end
    end

    if (PULSE_MASK != '0) begin : g_pulse
        cy_ctrl_pulse_gen #(
            .WIDTH    (WIDTH),
            .PULSE_LEN(PULSE_LEN)
        ) u_pulse_gen (
            .i_clock      (clock),
            .i_reset_n    (reset_n),
            .i_launch     (w_launch),
            .i_launch_mask(w_launch_mask),
            .o_pulse      (w_pulse),
            .o_busy       (w_busy)
        );
    end else begin : g_no_pulse
        logic w_unused_launch;
        assign w_unused_launch = w_launch ^ (|w_launch_mask);
        assign w_pulse         = '0;
        assign w_busy          = 1'b0;
    end

    assign control      = r_level | w_pulse;
    assign bus_rdata    = r_rdata;
    assign bus_ack      = r_ack;
    assign pending      = r_pending;
    assign pulse_active = w_busy;

endmodule

// File: tb/tb_cy_control_reg_ext.sv
// Directed bench for cy_control_reg_ext: five instances cover reset value,
// immediate access, pulse length, pulse relaunch and staged commit.
module tb_cy_control_reg_ext;

    localparam int NDUT = 5;
    localparam logic [7:0] PM_T  [NDUT] = '{8'h01, 8'h00, 8'h80, 8'hC0, 8'h80};
    localparam logic [7:0] RV_T  [NDUT] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    localparam int         LEN_T [NDUT] = '{1, 1, 3, 4, 2};
    localparam int         STG_T [NDUT] = '{0, 0, 0, 0, 1};

    logic            clk;
    logic            rst_n;
    logic [NDUT-1:0] wr, rd, cm, ack, pend, pact;
    logic [7:0]      wd    [NDUT];
    logic [7:0]      rdata [NDUT];
    logic [7:0]      ctrl  [NDUT];

    int n_checks;
    int n_fail;

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        cy_control_reg_ext #(
            .WIDTH     (8),
            .PULSE_MASK(PM_T[gi]),
            .PULSE_LEN (LEN_T[gi]),
            .STAGED    (STG_T[gi]),
            .RESET_VAL (RV_T[gi])
        ) u_dut (
            .clock       (clk),
            .reset_n     (rst_n),
            .bus_wr      (wr[gi]),
            .bus_wdata   (wd[gi]),
            .bus_rd      (rd[gi]),
            .bus_rdata   (rdata[gi]),
            .bus_ack     (ack[gi]),
            .commit      (cm[gi]),
            .control     (ctrl[gi]),
            .pending     (pend[gi]),
            .pulse_active(pact[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       rd;
        logic       cm;
        logic [7:0] wd;
        logic [7:0] ctrl;
        logic       ack;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end else begin
            $display("ok   %s = %02h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = '0;
        rd = '0;
        cm = '0;
    endtask

    logic [7:0] exp2 [5];
    logic [7:0] exp3 [7];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        idle();
        for (int i = 0; i < NDUT; i++) wd[i] = 8'h00;

        tbl[0] = '{wr:1'b1, rd:1'b0, cm:1'b0, wd:8'h3C, ctrl:8'h3C, ack:1'b1, rdata:8'h00};
        tbl[1] = '{wr:1'b0, rd:1'b0, cm:1'b0, wd:8'h00, ctrl:8'h3C, ack:1'b0, rdata:8'h00};
        tbl[2] = '{wr:1'b0, rd:1'b1, cm:1'b0, wd:8'h00, ctrl:8'h3C, ack:1'b1, rdata:8'h3C};
        tbl[3] = '{wr:1'b0, rd:1'b1, cm:1'b0, wd:8'h00, ctrl:8'h3C, ack:1'b1, rdata:8'h3C};
        tbl[4] = '{wr:1'b1, rd:1'b1, cm:1'b0, wd:8'hF0, ctrl:8'hF0, ack:1'b1, rdata:8'h3C};
        tbl[5] = '{wr:1'b1, rd:1'b0, cm:1'b1, wd:8'h00, ctrl:8'h00, ack:1'b1, rdata:8'h00};
        tbl[6] = '{wr:1'b0, rd:1'b1, cm:1'b0, wd:8'h00, ctrl:8'h00, ack:1'b1, rdata:8'h00};
        tbl[7] = '{wr:1'b0, rd:1'b0, cm:1'b1, wd:8'h00, ctrl:8'h00, ack:1'b0, rdata:8'h00};
        exp2 = '{8'h81, 8'h81, 8'h81, 8'h01, 8'h01};
        exp3 = '{8'h80, 8'h80, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'h00};

        // Reset
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst ctrl0", ctrl[0], 8'hA4);
        chk("rst ack0", {7'b0, ack[0]}, 8'h00);
        chk("rst pend0", {7'b0, pend[0]}, 8'h00);
        chk("rst pact0", {7'b0, pact[0]}, 8'h00);
        chk("rst rdata1", rdata[1], 8'h00);
        chk("rst ctrl4", ctrl[4], 8'h00);
        chk("rst pend4", {7'b0, pend[4]}, 8'h00);

        // Immediate mode, table driven
        for (int i = 0; i < 8; i++) begin
            wr[1] = tbl[i].wr;
            rd[1] = tbl[i].rd;
            cm[1] = tbl[i].cm;
            wd[1] = tbl[i].wd;
            step();
            idle();
            chk($sformatf("imm[%0d] ctrl", i), ctrl[1], tbl[i].ctrl);
            chk($sformatf("imm[%0d] ack", i), {7'b0, ack[1]}, {7'b0, tbl[i].ack});
            chk($sformatf("imm[%0d] pend", i), {7'b0, pend[1]}, 8'h00);
            if (tbl[i].rd) chk($sformatf("imm[%0d] rdata", i), rdata[1], tbl[i].rdata);
        end

        // PULSE_LEN=1 with a mixed level/pulse write
        wr[0] = 1'b1; wd[0] = 8'h03;
        step();
        idle();
        chk("len1 ctrl c1", ctrl[0], 8'h03);
        chk("len1 pact c1", {7'b0, pact[0]}, 8'h01);
        step();
        chk("len1 ctrl c2", ctrl[0], 8'h02);
        chk("len1 pact c2", {7'b0, pact[0]}, 8'h00);
        rd[0] = 1'b1;
        step();
        idle();
        chk("len1 rdata", rdata[0], 8'h02);

        // PULSE_LEN=3: bit7 high exactly three cycles
        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                wr[2] = 1'b1; wd[2] = 8'h81;
            end
            step();
            idle();
            chk($sformatf("len3[%0d] ctrl", k), ctrl[2], exp2[k]);
            chk($sformatf("len3[%0d] pact", k), {7'b0, pact[2]}, (k < 3) ? 8'h01 : 8'h00);
        end
        rd[2] = 1'b1;
        step();
        idle();
        chk("len3 rdata", rdata[2], 8'h01);

        // Relaunch stretches bit7 to six cycles, bit6 gets four
        for (int k = 0; k < 7; k++) begin
            if (k == 0) begin
                wr[3] = 1'b1; wd[3] = 8'h80;
            end else if (k == 2) begin
                wr[3] = 1'b1; wd[3] = 8'hC0;
            end
            step();
            idle();
            chk($sformatf("relaunch[%0d] ctrl", k), ctrl[3], exp3[k]);
            chk($sformatf("relaunch[%0d] pact", k), {7'b0, pact[3]}, (k < 6) ? 8'h01 : 8'h00);
        end

        // Staged commit
        wr[4] = 1'b1; wd[4] = 8'h55;
        step();
        idle();
        chk("stg wr ctrl", ctrl[4], 8'h00);
        chk("stg wr pend", {7'b0, pend[4]}, 8'h01);
        chk("stg wr ack", {7'b0, ack[4]}, 8'h01);
        rd[4] = 1'b1;
        step();
        idle();
        chk("stg rd rdata", rdata[4], 8'h55);
        cm[4] = 1'b1;
        step();
        idle();
        chk("stg cm ctrl", ctrl[4], 8'h55);
        chk("stg cm pend", {7'b0, pend[4]}, 8'h00);

        // Write and commit on the same edge
        wr[4] = 1'b1; wd[4] = 8'h11;
        step();
        idle();
        chk("col pre ctrl", ctrl[4], 8'h55);
        wr[4] = 1'b1; wd[4] = 8'h22; cm[4] = 1'b1;
        step();
        idle();
        chk("col ctrl", ctrl[4], 8'h11);
        chk("col pend", {7'b0, pend[4]}, 8'h01);
        rd[4] = 1'b1;
        step();
        idle();
        chk("col staging", rdata[4], 8'h22);
        cm[4] = 1'b1;
        step();
        idle();
        chk("col cm2 ctrl", ctrl[4], 8'h22);
        chk("col cm2 pend", {7'b0, pend[4]}, 8'h00);
        cm[4] = 1'b1;
        step();
        idle();
        chk("recommit ctrl", ctrl[4], 8'h22);
        chk("recommit pact", {7'b0, pact[4]}, 8'h00);

        // Pulse launched from staging
        wr[4] = 1'b1; wd[4] = 8'h83;
        step();
        idle();
        chk("stgp wr ctrl", ctrl[4], 8'h22);
        cm[4] = 1'b1;
        step();
        idle();
        chk("stgp c1 ctrl", ctrl[4], 8'h83);
        chk("stgp c1 pact", {7'b0, pact[4]}, 8'h01);
        rd[4] = 1'b1;
        step();
        idle();
        chk("stgp c2 ctrl", ctrl[4], 8'h83);
        chk("stgp rdata", rdata[4], 8'h03);
        step();
        chk("stgp c3 ctrl", ctrl[4], 8'h03);
        chk("stgp c3 pact", {7'b0, pact[4]}, 8'h00);

        // Asynchronous reset in the middle of a pulse
        wr[4] = 1'b1; wd[4] = 8'h80;
        step();
        idle();
        cm[4] = 1'b1;
        step();
        idle();
        chk("mid ctrl", ctrl[4], 8'h80);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst ctrl4", ctrl[4], 8'h00);
        chk("arst pact4", {7'b0, pact[4]}, 8'h00);
        chk("arst pend4", {7'b0, pend[4]}, 8'h00);
        chk("arst ctrl0", ctrl[0], 8'hA4);
        #1;
        rst_n = 1'b1;
        step();
        chk("post rst ctrl4", ctrl[4], 8'h00);
        chk("post rst pact4", {7'b0, pact[4]}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cy_control_reg_ext.md
Name: cy_control_reg_ext

Overview:
- Parametrised successor to the fixed 8-bit control register.
- CPU-side register whose bits drive fabric nets.
- Adds configurable width, per-bit pulse (self-clearing strobe) mode with programmable pulse length, optional staged/atomic commit, and a registered write/read handshake with readback.
- Sits between the bus bridge and fabric logic (counters, muxes, enables) that need glitch-free, simultaneously updated control bits.

Parameters:
- WIDTH, 8: number of control bits, legal 1..32.
- PULSE_MASK, 0: WIDTH-bit mask; bit i = 1 puts control bit i in pulse mode, 0 = level mode.
- PULSE_LEN, 1: cycles a pulse bit stays high, legal 1..16.
- STAGED, 0: 0 = writes take effect immediately; 1 = writes go to a staging register and apply only on commit.
- RESET_VAL, 0: WIDTH-bit reset value of level bits. Pulse bits always reset to 0.

Ports:
- clock  input  1  single block clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- bus_wr  input  1  write request, one-cycle qualifier.
- bus_wdata  input  WIDTH  write data.
- bus_rd  input  1  read request.
- bus_rdata  output  WIDTH  readback data, valid with bus_ack.
- bus_ack  output  1  one-cycle acknowledge for rd or wr.
- commit  input  1  apply staged value (STAGED=1 only).
- control  output  WIDTH  registered control nets to fabric.
- pending  output  1  staging holds an unapplied write.
- pulse_active  output  1  a pulse is in progress.

Behaviour:
- Reset (reset_n low, asynchronous):
  - control = RESET_VAL & ~PULSE_MASK; staging = same value.
  - bus_ack = 0, bus_rdata = 0, pending = 0, pulse_active = 0, pulse counter = 0.
- Handshake:
  - bus_wr or bus_rd sampled high at edge N gives bus_ack high during cycle N+1 for exactly one cycle.
  - Back-to-back requests are allowed; each gets its own ack.
  - bus_wr and bus_rd both high: write wins; the acked bus_rdata shows the pre-write value.
- Immediate mode (STAGED=0):
  - Write at edge N: level bits of control update at edge N (visible in cycle N+1, same cycle as ack).
  - Pulse bits written 1 launch a pulse; written 0 have no effect.
  - commit is ignored; pending stays 0.
- Staged mode (STAGED=1):
  - A write loads staging and sets pending.
  - commit sampled high: control level bits <= staging level bits; pulse bits set in staging launch a pulse; pulse bits in staging clear; pending clears.
  - commit with pending=0 re-applies staging: level bits unchanged, no pulse.
  - bus_wr and commit on the same edge: commit applies the OLD staging, the new data lands in staging, and pending stays 1.
- Pulse engine:
  - One shared down-counter, 5 bits, plus an active-bit set.
  - Launch: active set |= new bits; counter <= PULSE_LEN; control pulse bits = active set while counter != 0.
  - Each cycle the counter decrements; at 0 the active set clears.
  - Result: each pulse bit is high for exactly PULSE_LEN cycles starting the cycle after launch.
  - Relaunch while active: new bits OR into the set and the counter restarts at PULSE_LEN, stretching already-active bits.
  - pulse_active = (counter != 0).
- Readback:
  - bus_rdata = control level bits; pulse bits read 0.
  - In STAGED mode, level bits read the staging value, pulse bits read the staging value.
- Width rule: bus_wdata bits above WIDTH do not exist; with PULSE_MASK = 0 no counter logic remains.
- Reset mid-pulse or mid-stage drops everything to reset values immediately; no pulse completes.

Decomposition:
- Shared package cy_ctrl_pkg:
  - constants CY_CTRL_MAX_WIDTH = 32 and CY_CTRL_MAX_PULSE = 16;
  - an elaboration-time check function for parameter legality.
- One sub-module, cy_ctrl_pulse_gen: counter plus active-set register; inputs launch mask and launch strobe; outputs pulse vector and busy.
- Register, staging and handshake logic stay in the top module.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=0xA5, PULSE_MASK=0x01 -> after reset control=0xA4, bus_ack=0, pending=0.
- Immediate write: bus_wr with 0x3C, PULSE_MASK=0 -> control=0x3C and bus_ack=1 in the next cycle. Then a read returns 0x3C with ack one cycle later.
- Pulse length: PULSE_MASK=0x80, PULSE_LEN=3, write 0x81 -> bit7 high exactly 3 cycles then 0; bit0 stays 1; read returns 0x01.
- Pulse relaunch: PULSE_LEN=4, write 0x80, then write 0xC0 two cycles later (PULSE_MASK=0xC0) -> bit7 high 6 cycles total, bit6 high 4 cycles, both fall together.
- Staged commit: STAGED=1, write 0x55 -> control unchanged and pending=1. Assert commit -> control=0x55 next cycle and pending=0.
- Collision: STAGED=1 with staging=0x11 pending; bus_wr 0x22 and commit on the same edge -> control=0x11, staging=0x22, pending=1. A later commit gives control=0x22. Assert reset_n low mid-pulse -> control returns to RESET_VAL asynchronously.
